// File: rtl/iomem_dbg_if.sv
// ---------------------------------------------------------------------------
// iomem_dbg_if
//   Bundles the three interfaces of the iomem debug bridge:
//     rx_*     upstream command byte stream (UART RX decoder -> bridge)
//     tx_*     downstream response byte stream (bridge -> UART TX encoder)
//     iomem_*  picosoc iomem bus (bridge is the initiator)
//     busy     bridge status
//   modport master : the bridge side (drives iomem requests and tx bytes)
//   modport slave  : the environment side (byte source/sink and responder)
// ---------------------------------------------------------------------------
interface iomem_dbg_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic        busy;

  modport master (
    input  rx_data, rx_valid, tx_ready, iomem_ready, iomem_rdata,
    output rx_ready, tx_data, tx_valid, iomem_valid, iomem_wstrb,
           iomem_addr, iomem_wdata, busy
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, iomem_ready, iomem_rdata,
    input  rx_ready, tx_data, tx_valid, iomem_valid, iomem_wstrb,
           iomem_addr, iomem_wdata, busy
  );
endinterface

// File: rtl/iomem_dbg_bridge.sv
// ---------------------------------------------------------------------------
// iomem_dbg_bridge
//   Debug bus initiator: decodes command frames arriving on a byte stream and
//   issues single-word iomem reads/writes, answering on a byte stream.
//     write frame : 57 A3 A2 A1 A0 D3 D2 D1 D0 -> 06 (ok) / 15 (timeout)
//     read frame  : 52 A3 A2 A1 A0             -> R3 R2 R1 R0 / 15
//     other opcode: -> 3F
// Parameters
//   TIMEOUT : max cycles iomem_valid waits for iomem_ready (1..65535)
// Ports
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   bus   : iomem_dbg_if.master (rx stream, tx stream, iomem bus, busy)
// ---------------------------------------------------------------------------
module iomem_dbg_bridge #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  iomem_dbg_if.master bus
);

  localparam logic [7:0]  OP_WRITE = 8'h57;
  localparam logic [7:0]  OP_READ  = 8'h52;
  localparam logic [7:0]  RSP_ACK  = 8'h06;
  localparam logic [7:0]  RSP_NAK  = 8'h15;
  localparam logic [7:0]  RSP_BAD  = 8'h3F;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

  state_t      r_state;
  logic [1:0]  r_byte_cnt;    // bytes taken in ADDR/DATA; bytes left in RESP
  logic        r_is_write;
  logic [15:0] r_timer;
  logic [23:0] r_rd_shift;    // remaining read-response bytes, MSB first
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;
  logic        r_iomem_valid;
  logic [3:0]  r_iomem_wstrb;
  logic [31:0] r_iomem_addr;
  logic [31:0] r_iomem_wdata;

  logic w_rx_ready;
  logic w_rx_take;
  logic w_tx_take;

  // The reset term keeps rx_ready low for the whole reset pulse, not just
  // until the state register has settled to IDLE.
  assign w_rx_ready = !reset &&
                      (r_state == S_IDLE || r_state == S_ADDR || r_state == S_DATA);
  assign w_rx_take  = bus.rx_valid & w_rx_ready;
  assign w_tx_take  = r_tx_valid & bus.tx_ready;

  assign bus.rx_ready    = w_rx_ready;
  assign bus.tx_data     = r_tx_data;
  assign bus.tx_valid    = r_tx_valid;
  assign bus.iomem_valid = r_iomem_valid;
  assign bus.iomem_wstrb = r_iomem_wstrb;
  assign bus.iomem_addr  = r_iomem_addr;
  assign bus.iomem_wdata = r_iomem_wdata;
  assign bus.busy        = (r_state != S_IDLE);

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_byte_cnt    <= 2'd0;
      r_is_write    <= 1'b0;
      r_timer       <= 16'd0;
      r_rd_shift    <= 24'd0;
      r_tx_data     <= 8'd0;
      r_tx_valid    <= 1'b0;
      r_iomem_valid <= 1'b0;
      r_iomem_wstrb <= 4'd0;
      r_iomem_addr  <= 32'd0;
      r_iomem_wdata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rx_take) begin
            r_byte_cnt <= 2'd0;
            if (bus.rx_data == OP_WRITE || bus.rx_data == OP_READ) begin
              r_is_write <= (bus.rx_data == OP_WRITE);
              r_state    <= S_ADDR;
            end else begin
              r_tx_data  <= RSP_BAD;
              r_tx_valid <= 1'b1;
              r_state    <= S_RESP;
            end
          end
        end

        S_ADDR: begin
          if (w_rx_take) begin
            r_iomem_addr <= {r_iomem_addr[23:0], bus.rx_data};
            r_byte_cnt   <= r_byte_cnt + 2'd1;   // wraps to 0 for DATA
            if (r_byte_cnt == 2'd3) begin
              if (r_is_write) begin
                r_state <= S_DATA;
              end else begin
                r_iomem_valid <= 1'b1;
                r_iomem_wstrb <= 4'h0;
                r_timer       <= 16'd0;
                r_state       <= S_BUS;
              end
            end
          end
        end

        S_DATA: begin
          if (w_rx_take) begin
            r_iomem_wdata <= {r_iomem_wdata[23:0], bus.rx_data};
            r_byte_cnt    <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_iomem_valid <= 1'b1;
              r_iomem_wstrb <= 4'hF;
              r_timer       <= 16'd0;
              r_state       <= S_BUS;
            end
          end
        end

        S_BUS: begin
          // Ready wins over timeout when both land in the same cycle.
          if (bus.iomem_ready) begin
            r_iomem_valid <= 1'b0;
            r_iomem_wstrb <= 4'h0;
            r_tx_valid    <= 1'b1;
            r_state       <= S_RESP;
            if (r_is_write) begin
              r_tx_data  <= RSP_ACK;
              r_byte_cnt <= 2'd0;
            end else begin
              r_tx_data  <= bus.iomem_rdata[31:24];
              r_rd_shift <= bus.iomem_rdata[23:0];
              r_byte_cnt <= 2'd3;
            end
          end else if (r_timer == TMO_LAST) begin
            r_iomem_valid <= 1'b0;
            r_iomem_wstrb <= 4'h0;
            r_tx_data     <= RSP_NAK;
            r_tx_valid    <= 1'b1;
            r_byte_cnt    <= 2'd0;
            r_state       <= S_RESP;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end

        S_RESP: begin
          if (w_tx_take) begin
            if (r_byte_cnt == 2'd0) begin
              r_tx_valid <= 1'b0;
              r_state    <= S_IDLE;
            end else begin
              r_tx_data  <= r_rd_shift[23:16];
              r_rd_shift <= {r_rd_shift[15:0], 8'h00};
              r_byte_cnt <= r_byte_cnt - 2'd1;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iomem_dbg_bridge.sv
// ---------------------------------------------------------------------------
// tb_iomem_dbg_bridge
//   Directed bench for iomem_dbg_bridge (TIMEOUT=16). Inputs are driven and
//   outputs sampled on the falling clock edge; an iomem responder model
//   counts valid cycles, captures the request and checks it stays stable.
// ---------------------------------------------------------------------------
module tb_iomem_dbg_bridge;

  logic clk = 1'b0;
  logic reset;

  iomem_dbg_if bus_if ();

  iomem_dbg_bridge #(.TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  // ---------------- iomem responder model ----------------
  int          rsp_delay;     // ready in this valid cycle (1-based); 0 = never
  logic [31:0] rsp_rdata;
  logic        force_ready;   // stray ready while bus is idle
  int          vcnt;
  int          stable_err;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_wstrb;

  always @(negedge clk) begin
    if (bus_if.iomem_valid) begin
      vcnt++;
      if (vcnt == 1) begin
        cap_addr  = bus_if.iomem_addr;
        cap_wdata = bus_if.iomem_wdata;
        cap_wstrb = bus_if.iomem_wstrb;
      end else if (bus_if.iomem_addr !== cap_addr || bus_if.iomem_wdata !== cap_wdata ||
                   bus_if.iomem_wstrb !== cap_wstrb) begin
        stable_err++;
      end
      bus_if.iomem_ready = (rsp_delay != 0) && (vcnt == rsp_delay);
    end else begin
      bus_if.iomem_ready = force_ready;
    end
  end

  task automatic arm(input int delay, input logic [31:0] rdata);
    rsp_delay  = delay;
    rsp_rdata  = rdata;
    bus_if.iomem_rdata = rdata;
    vcnt       = 0;
    stable_err = 0;
  endtask

  // ---------------- byte stream helpers (called at negedge) ----------------
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus_if.rx_data  = b;
    bus_if.rx_valid = 1'b1;
    while (!bus_if.rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("rx_accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus_if.rx_valid = 1'b0;
  endtask

  task automatic recv_byte(input string tag, input logic [7:0] exp, input int stall);
    int n = 0;
    int bad = 0;
    logic [7:0] held;
    while (!bus_if.tx_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus_if.tx_valid) begin
      check({tag, "_tx_timeout"}, 32'd0, 32'd1);
      return;
    end
    held = bus_if.tx_data;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (bus_if.tx_data !== held || !bus_if.tx_valid || bus_if.rx_ready) bad++;
    end
    if (stall > 0) check({tag, "_stall"}, bad, 0);
    check(tag, {24'd0, held}, {24'd0, exp});
    bus_if.tx_ready = 1'b1;
    @(negedge clk);
    bus_if.tx_ready = 1'b0;
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d);
    send_byte(8'h57);
    for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
    for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8]);
  endtask

  task automatic send_read(input logic [31:0] a);
    send_byte(8'h52);
    for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
  endtask

  task automatic check_quiet(input string tag, input int cycles);
    int bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus_if.tx_valid || bus_if.iomem_valid || bus_if.busy) bad++;
    end
    check(tag, bad, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {31'd0, bus_if.iomem_valid}, 32'd0);
    check({tag, "_addr"},  bus_if.iomem_addr, 32'd0);
    check({tag, "_wdata"}, bus_if.iomem_wdata, 32'd0);
    check({tag, "_wstrb"}, {28'd0, bus_if.iomem_wstrb}, 32'd0);
    check({tag, "_txv"},   {31'd0, bus_if.tx_valid}, 32'd0);
    check({tag, "_txd"},   {24'd0, bus_if.tx_data}, 32'd0);
    check({tag, "_busy"},  {31'd0, bus_if.busy}, 32'd0);
    check({tag, "_rxrdy"}, {31'd0, bus_if.rx_ready}, 32'd0);
  endtask

  initial begin
    reset              = 1'b1;
    bus_if.rx_data     = 8'd0;
    bus_if.rx_valid    = 1'b0;
    bus_if.tx_ready    = 1'b0;
    bus_if.iomem_ready = 1'b0;
    bus_if.iomem_rdata = 32'd0;
    force_ready        = 1'b0;
    arm(0, 32'd0);

    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b0;
    @(negedge clk);
    check("idle_rx_ready", {31'd0, bus_if.rx_ready}, 32'd1);

    // 1. write, ready on 3rd valid cycle
    arm(3, 32'd0);
    send_write(32'h0300_0000, 32'h0000_00A5);
    recv_byte("wr_ack", 8'h06, 0);
    check("wr_addr",   cap_addr, 32'h0300_0000);
    check("wr_wdata",  cap_wdata, 32'h0000_00A5);
    check("wr_wstrb",  {28'd0, cap_wstrb}, 32'hF);
    check("wr_vcycles", vcnt, 3);
    check("wr_stable", stable_err, 0);

    // 2. read, ready on first valid cycle
    arm(1, 32'h1234_5678);
    send_read(32'h0300_0000);
    recv_byte("rd_b3", 8'h12, 0);
    recv_byte("rd_b2", 8'h34, 0);
    recv_byte("rd_b1", 8'h56, 0);
    recv_byte("rd_b0", 8'h78, 0);
    check("rd_wstrb",   {28'd0, cap_wstrb}, 32'h0);
    check("rd_addr",    cap_addr, 32'h0300_0000);
    check("rd_vcycles", vcnt, 1);
    check_quiet("rd_idle_after", 3);

    // 3. read timeout, then a late stray ready, then a good read
    arm(0, 32'h0);
    send_read(32'h0300_0004);
    recv_byte("tmo_nak", 8'h15, 0);
    check("tmo_vcycles", vcnt, 16);
    check("tmo_stable", stable_err, 0);
    force_ready = 1'b1;
    @(negedge clk);
    force_ready = 1'b0;
    check_quiet("tmo_late_ready", 4);
    arm(2, 32'hA1B2_C3D4);
    send_read(32'h0000_0010);
    recv_byte("tmo_next_b3", 8'hA1, 0);
    recv_byte("tmo_next_b2", 8'hB2, 0);
    recv_byte("tmo_next_b1", 8'hC3, 0);
    recv_byte("tmo_next_b0", 8'hD4, 0);
    check("tmo_next_vcycles", vcnt, 2);

    // 4. bad opcode then a normal read
    arm(1, 32'hDEAD_BEEF);
    send_byte(8'h41);
    recv_byte("bad_op", 8'h3F, 0);
    check("bad_op_no_bus", vcnt, 0);
    send_read(32'h0300_0000);
    recv_byte("bad_rd_b3", 8'hDE, 0);
    recv_byte("bad_rd_b2", 8'hAD, 0);
    recv_byte("bad_rd_b1", 8'hBE, 0);
    recv_byte("bad_rd_b0", 8'hEF, 0);

    // 5. read with a 10-cycle downstream stall on every byte
    arm(1, 32'hCAFE_F00D);
    send_read(32'h0300_0008);
    recv_byte("stall_b3", 8'hCA, 10);
    recv_byte("stall_b2", 8'hFE, 10);
    recv_byte("stall_b1", 8'hF0, 10);
    recv_byte("stall_b0", 8'h0D, 10);
    check("stall_rx_ready_back", {31'd0, bus_if.rx_ready}, 32'd1);

    // 6a. reset in the middle of the data bytes
    arm(1, 32'h0);
    send_byte(8'h57);
    for (int i = 0; i < 4; i++) send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_data");
    @(negedge clk);
    reset = 1'b0;
    check_quiet("rst_data_quiet", 4);

    // 6b. reset while the bus request is outstanding
    arm(0, 32'h0);
    send_read(32'h0300_0000);
    repeat (3) @(negedge clk);
    check("rst_bus_pre_valid", {31'd0, bus_if.iomem_valid}, 32'd1);
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_bus");
    @(negedge clk);
    reset = 1'b0;
    check_quiet("rst_bus_quiet", 4);

    // fresh write after reset
    arm(2, 32'h0);
    send_write(32'h0300_0000, 32'h5A5A_0F0F);
    recv_byte("post_rst_ack", 8'h06, 0);
    check("post_rst_addr",  cap_addr, 32'h0300_0000);
    check("post_rst_wdata", cap_wdata, 32'h5A5A_0F0F);
    check("post_rst_vcycles", vcnt, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
